// File: rtl/result_scanner_pkg.sv
// Shared definitions for the path-delay result scanner: FSM encoding,
// report framing constants and the byte selector used by the sender.
package result_scanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_WAIT_FIN = 3'd2,
        ST_SEND     = 3'd3,
        ST_NEXT     = 3'd4,
        ST_DONE     = 3'd5
    } scan_state_e;

    localparam logic [3:0]  HDR_NIBBLE       = 4'hA;
    localparam int          BYTES_PER_PATH   = 5;
    localparam logic [31:0] TIMEOUT_SENTINEL = 32'hFFFF_FFFF;

    // Byte idx of one path report: header first, then the held value MSB first.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic        status,
                                              input logic [2:0]  path,
                                              input logic [31:0] hold);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {HDR_NIBBLE, status, path};
            3'd1:    b = hold[31:24];
            3'd2:    b = hold[23:16];
            3'd3:    b = hold[15:8];
            default: b = hold[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/result_scanner_uart_tx.sv
// 8N1 UART transmitter. A byte is accepted on a cycle with valid && ready.
// ready is also raised during the final cycle of the stop bit, so a byte
// offered then starts its start bit on the very next cycle (no idle gap).
module uart_tx #(
    parameter int CLKS_PER_BIT = 2170
) (
    input  logic       clk250,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       tx,
    output logic       ready
);

    localparam int             CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [9:0]       r_frame;
    logic             r_active;
    logic [3:0]       r_bit_idx;
    logic [CNT_W-1:0] r_clk_cnt;

    logic w_bit_end;
    logic w_last;
    logic w_accept;

    assign w_bit_end = (r_clk_cnt == CNT_LAST);
    assign w_last    = r_active && w_bit_end && (r_bit_idx == 4'd9);
    assign ready     = !r_active || w_last;
    assign w_accept  = valid && ready;
    // Idle line is the all-ones frame, so tx comes straight from a flop.
    assign tx        = r_frame[0];

    // Load a frame on accept, otherwise shift one bit every CLKS_PER_BIT cycles.
    always_ff @(posedge clk250 or posedge rst) begin
        if (rst) begin
            r_frame   <= '1;
            r_active  <= 1'b0;
            r_bit_idx <= 4'd0;
            r_clk_cnt <= '0;
        end else if (w_accept) begin
            r_frame   <= {1'b1, data, 1'b0};
            r_active  <= 1'b1;
            r_bit_idx <= 4'd0;
            r_clk_cnt <= '0;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_clk_cnt <= '0;
                if (r_bit_idx == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_bit_idx <= r_bit_idx + 4'd1;
                    r_frame   <= {1'b1, r_frame[9:1]};
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/result_scanner.sv
// Steps the measurement mux through paths 0..7, waits for each path's
// fin flag (or a timeout), and reports every path as five UART bytes.
// o_state exposes the FSM state for debug and checkers.
module result_scanner
    import result_scanner_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 2170,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 16777216
) (
    input  logic        clk250,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] result,
    input  logic        fin,
    output logic [2:0]  SW,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output scan_state_e o_state
);

    localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    scan_state_e r_state;
    logic [2:0]  r_path;
    logic [2:0]  r_sw;
    logic        r_busy;
    logic        r_done;
    logic        r_status;
    logic [31:0] r_hold;
    logic [31:0] r_settle_cnt;
    logic [31:0] r_timeout_cnt;
    logic [2:0]  r_byte_idx;

    logic       w_tx_valid;
    logic       w_tx_ready;
    logic [7:0] w_tx_data;

    // Offer bytes while the current path report is incomplete.
    assign w_tx_valid = (r_state == ST_SEND) && (r_byte_idx < 3'(BYTES_PER_PATH));
    assign w_tx_data  = frame_byte(r_byte_idx, r_status, r_path, r_hold);

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk250(clk250),
        .rst   (rst),
        .data  (w_tx_data),
        .valid (w_tx_valid),
        .tx    (tx),
        .ready (w_tx_ready)
    );

    // Scan sequencer: settle, wait for fin or timeout, send report, advance.
    always_ff @(posedge clk250 or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_path        <= 3'd0;
            r_sw          <= 3'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_status      <= 1'b0;
            r_hold        <= 32'd0;
            r_settle_cnt  <= 32'd0;
            r_timeout_cnt <= 32'd0;
            r_byte_idx    <= 3'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sw         <= 3'd0;
                        r_path       <= 3'd0;
                        r_busy       <= 1'b1;
                        r_settle_cnt <= 32'd0;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_timeout_cnt <= 32'd0;
                        r_state       <= ST_WAIT_FIN;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 32'd1;
                    end
                end
                ST_WAIT_FIN: begin
                    // fin is checked first so it wins over a coincident timeout.
                    if (fin) begin
                        r_hold     <= result;
                        r_status   <= 1'b0;
                        r_byte_idx <= 3'd0;
                        r_state    <= ST_SEND;
                    end else if (r_timeout_cnt == TIMEOUT_LAST) begin
                        r_hold     <= TIMEOUT_SENTINEL;
                        r_status   <= 1'b1;
                        r_byte_idx <= 3'd0;
                        r_state    <= ST_SEND;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 32'd1;
                    end
                end
                ST_SEND: begin
                    // After the last accept, ready returns in the final stop-bit cycle.
                    if (w_tx_valid && w_tx_ready) begin
                        r_byte_idx <= r_byte_idx + 3'd1;
                    end else if (!w_tx_valid && w_tx_ready) begin
                        r_state <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (r_path == 3'd7) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_path       <= r_path + 3'd1;
                        r_sw         <= r_path + 3'd1;
                        r_settle_cnt <= 32'd0;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign SW      = r_sw;
    assign busy    = r_busy;
    assign done    = r_done;
    assign o_state = r_state;

endmodule

// File: tb/tb_result_scanner.sv
// Bench for result_scanner: a measurement-mux model drives fin/result,
// a UART decoder feeds a byte scoreboard, and side monitors watch SW,
// done and busy.
`timescale 1ns/1ps
module tb_result_scanner;
    import result_scanner_pkg::*;

    localparam int CPB    = 4;
    localparam int SETTLE = 2;
    localparam int TMO    = 64;

    // ---------------- clock / reset ----------------
    logic        clk250 = 1'b0;
    logic        rst    = 1'b0;
    logic        start  = 1'b0;
    logic        fin    = 1'b0;
    logic [31:0] result = 32'd0;
    logic [2:0]  SW;
    logic        tx;
    logic        busy;
    logic        done;
    scan_state_e dbg_state;

    always #5 clk250 = ~clk250;

    result_scanner #(
        .CLKS_PER_BIT  (CPB),
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk250 (clk250),
        .rst    (rst),
        .start  (start),
        .result (result),
        .fin    (fin),
        .SW     (SW),
        .tx     (tx),
        .busy   (busy),
        .done   (done),
        .o_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- measurement mux model ----------------
    // m_cnt restarts when SW changes or a scan begins; fin rises after
    // cfg_delay cycles; toggling paths flip result every cycle after fin.
    int          cfg_delay[8];
    logic [31:0] cfg_res[8];
    logic        cfg_toggle[8];
    int          m_cnt = 0;
    logic [2:0]  m_sw_prev = 3'd0;
    logic        m_busy_prev = 1'b0;

    always @(negedge clk250) begin
        if (SW !== m_sw_prev || (busy && !m_busy_prev)) m_cnt = 0;
        else if (m_cnt < 1000000) m_cnt = m_cnt + 1;
        m_sw_prev   = SW;
        m_busy_prev = busy;
        fin = (m_cnt >= cfg_delay[SW]);
        if (cfg_toggle[SW] && m_cnt > cfg_delay[SW] && m_cnt[0]) result = ~cfg_res[SW];
        else result = cfg_res[SW];
    end

    // ---------------- driver tasks ----------------
    task automatic push_path(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
        exp_q.push_back(b4);
    endtask

    task automatic cfg_scan_a();
        for (int p = 0; p < 8; p++) begin
            cfg_delay[p]  = 10;
            cfg_res[p]    = 32'h0000_1234 + 32'(p);
            cfg_toggle[p] = 1'b0;
        end
    endtask

    task automatic push_scan_a();
        for (int p = 0; p < 8; p++)
            push_path(8'hA0 | 8'(p), 8'h00, 8'h00, 8'h12, 8'h34 + 8'(p));
    endtask

    task automatic cfg_scan_b();
        for (int p = 0; p < 8; p++) cfg_toggle[p] = 1'b0;
        cfg_delay[0] = 3;    cfg_res[0] = 32'h8000_0001;
        cfg_delay[1] = 64;   cfg_res[1] = 32'h0102_0304;
        cfg_delay[2] = 65;   cfg_res[2] = 32'hDEAD_BEEF;   // fin lands on the timeout cycle
        cfg_delay[3] = 10;   cfg_res[3] = 32'h5A5A_F00F;   cfg_toggle[3] = 1'b1;
        cfg_delay[4] = 66;   cfg_res[4] = 32'h1111_1111;   // one cycle too late
        cfg_delay[5] = 1000; cfg_res[5] = 32'h2222_2222;   // never
        cfg_delay[6] = 10;   cfg_res[6] = 32'h0000_0006;
        cfg_delay[7] = 10;   cfg_res[7] = 32'hFFFF_FFFE;
    endtask

    task automatic push_scan_b();
        push_path(8'hA0, 8'h80, 8'h00, 8'h00, 8'h01);
        push_path(8'hA1, 8'h01, 8'h02, 8'h03, 8'h04);
        push_path(8'hA2, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
        push_path(8'hA3, 8'h5A, 8'h5A, 8'hF0, 8'h0F);
        push_path(8'hAC, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        push_path(8'hAD, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        push_path(8'hA6, 8'h00, 8'h00, 8'h00, 8'h06);
        push_path(8'hA7, 8'hFF, 8'hFF, 8'hFF, 8'hFE);
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk250);
            n++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no done pulse within %0d cycles", name, budget);
        end
    endtask

    // ---------------- UART decoder + scoreboard ----------------
    logic       rx_active = 1'b0;
    logic       rx_level  = 1'b1;
    logic       rx_stable = 1'b1;
    logic       expect_start = 1'b0;
    int         rx_bit = 0;
    int         rx_cyc = 0;
    int         rx_byte_in_path = 0;
    logic [7:0] rx_data = 8'd0;
    logic [2:0] rx_cur_path = 3'd0;

    task automatic deliver_byte(input logic [7:0] b);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: actual %02h expected none (queue empty)", b);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d", rx_byte_in_path), 32'(b), 32'(e));
            if (rx_byte_in_path == 0) begin
                check("sw_at_header", 32'(SW), 32'(e[2:0]));
                rx_cur_path = e[2:0];
            end
        end
        rx_byte_in_path++;
        if (rx_byte_in_path < BYTES_PER_PATH) expect_start = 1'b1;
        else rx_byte_in_path = 0;
    endtask

    always @(negedge clk250) begin
        if (rst) begin
            rx_active       = 1'b0;
            expect_start    = 1'b0;
            rx_byte_in_path = 0;
        end else if (!rx_active) begin
            if (expect_start) begin
                check("byte_gap", 32'(tx), 32'd0);
                expect_start = 1'b0;
            end
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_bit    = 0;
                rx_cyc    = 1;
                rx_level  = 1'b0;
                rx_stable = 1'b1;
            end
        end else begin
            if (rx_cyc == 0) begin
                rx_level  = tx;
                rx_stable = 1'b1;
                if (rx_bit >= 1 && rx_bit <= 8) rx_data[rx_bit-1] = tx;
            end else if (tx !== rx_level) begin
                rx_stable = 1'b0;
            end
            if (rx_cyc == CPB - 1) begin
                check("bit_period", 32'(rx_stable), 32'd1);
                rx_cyc = 0;
                if (rx_bit == 9) begin
                    rx_active = 1'b0;
                    check("stop_bit", 32'(rx_level), 32'd1);
                    deliver_byte(rx_data);
                end else begin
                    rx_bit++;
                end
            end else begin
                rx_cyc++;
            end
        end
    end

    // ---------------- SW / done / busy monitor ----------------
    logic [2:0] sw_prev = 3'd0;
    logic       done_prev = 1'b0;
    int         done_cnt = 0;
    int         busy_cycles = 0;

    always @(negedge clk250) begin
        if (SW !== sw_prev)
            check("sw_change_legal",
                  32'(rst || (!rx_active && (SW == sw_prev + 3'd1 || SW == 3'd0))), 32'd1);
        sw_prev = SW;
        if (done === 1'b1) begin
            check("done_single_cycle", 32'(done_prev), 32'd0);
            check("busy_low_at_done", 32'(busy), 32'd0);
            done_cnt++;
        end
        done_prev = done;
        if (busy === 1'b1) busy_cycles++;
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int tx_low;
        cfg_scan_a();
        #1 rst = 1'b1;
        @(negedge clk250);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_sw", 32'(SW), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));

        // Scan A: release reset and raise start together; start is then held.
        push_scan_a();
        busy_cycles = 0;
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk250);
        check("busy_first_edge_after_reset", 32'(busy), 32'd1);
        wait_done(4000, "scan_a_done");
        n_checks++;
        if (busy_cycles < 1696 || busy_cycles > 1728) begin
            n_fail++;
            $display("FAIL scan_length: actual %0d cycles required 1696..1728", busy_cycles);
        end

        // Start still high: a new scan must follow straight after DONE.
        push_scan_a();
        @(negedge clk250);
        check("busy_low_after_done", 32'(busy), 32'd0);
        @(negedge clk250);
        check("restart_with_start_held", 32'(busy), 32'd1);
        start = 1'b0;
        check("done_count_a", 32'(done_cnt), 32'd1);
        check("queue_drained_a", 32'(exp_q.size()), 32'd40);

        // Reset in the middle of path 2, byte 3 (data bit 0 is low there).
        n = 0;
        while (!(rx_active && rx_cur_path == 3'd2 && rx_byte_in_path == 3) && n < 3000) begin
            @(negedge clk250);
            n++;
        end
        check("reached_path2_byte3", 32'(n < 3000), 32'd1);
        repeat (5) @(negedge clk250);
        #2 rst = 1'b1;
        #1;
        check("midbyte_rst_tx", 32'(tx), 32'd1);
        check("midbyte_rst_sw", 32'(SW), 32'd0);
        check("midbyte_rst_busy", 32'(busy), 32'd0);
        check("midbyte_rst_done", 32'(done), 32'd0);
        check("midbyte_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        @(negedge clk250);
        @(negedge clk250);
        #2 rst = 1'b0;

        // No partial frame may resume after release.
        tx_low = 0;
        repeat (30) begin
            @(negedge clk250);
            if (tx !== 1'b1 || busy !== 1'b0) tx_low++;
        end
        check("quiet_after_reset", 32'(tx_low), 32'd0);

        // Scan B: timeouts, fin on the timeout cycle, toggling result.
        cfg_scan_b();
        push_scan_b();
        start = 1'b1;
        @(negedge clk250);
        check("busy_after_start_b", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(6000, "scan_b_done");
        @(negedge clk250);
        @(negedge clk250);
        check("done_count_b", 32'(done_cnt), 32'd2);
        check("idle_after_b", 32'(busy), 32'd0);
        check("queue_empty_end", 32'(exp_q.size()), 32'd0);
        check("tx_idle_end", 32'(tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
